// File: rtl/speck_cipher_controller.sv
// SPECK128/128 sequencing controller: optional key expansion into a round-key
// buffer, then 32 encrypt/decrypt rounds at one round per clock.
module speck_cipher_controller #(
    parameter int ROUNDS = 32,
    parameter int WORD   = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              signal_start,
    input  logic              mode,
    input  logic              new_key,
    input  logic [2*WORD-1:0] key,
    input  logic [2*WORD-1:0] data_in,
    output logic [2*WORD-1:0] data_out,
    output logic              busy,
    output logic              finished,
    output logic              key_ready,
    output logic [3:0]        state_response
);
    localparam int CW = $clog2(ROUNDS);
    localparam logic [CW-1:0] LAST = CW'(ROUNDS - 1);

    typedef enum logic [3:0] {
        IDLE   = 4'd0,
        EXPAND = 4'd1,
        RUN    = 4'd2,
        DONE   = 4'd3
    } state_e;

    state_e            state_q;
    logic [CW-1:0]     cnt_q;
    logic              mode_q;
    logic [WORD-1:0]   x_q, y_q, k_q, l_q;
    logic [WORD-1:0]   rk_q [ROUNDS];
    logic [2*WORD-1:0] data_out_q;
    logic              busy_q, finished_q, key_ready_q;

    logic [WORD-1:0]   k_d, l_d, x_d, y_d, rk_sel, dec_y;
    logic              last;

    function automatic logic [WORD-1:0] ror(input logic [WORD-1:0] v, input int unsigned n);
        return (v >> n) | (v << (WORD - n));
    endfunction

    function automatic logic [WORD-1:0] rol(input logic [WORD-1:0] v, input int unsigned n);
        return (v << n) | (v >> (WORD - n));
    endfunction

    // Decrypt walks the buffer backwards so the same counter serves both modes.
    always_comb begin
        last   = (cnt_q == LAST);
        l_d    = (k_q + ror(l_q, 8)) ^ WORD'(cnt_q);
        k_d    = rol(k_q, 3) ^ l_d;
        rk_sel = mode_q ? rk_q[LAST - cnt_q] : rk_q[cnt_q];
        dec_y  = ror(x_q ^ y_q, 3);
        if (mode_q) begin
            y_d = dec_y;
            x_d = rol((x_q ^ rk_sel) - dec_y, 8);
        end else begin
            x_d = (ror(x_q, 8) + y_q) ^ rk_sel;
            y_d = rol(y_q, 3) ^ x_d;
        end
    end

    // Round-key storage carries no reset; key_ready guards its validity.
    always_ff @(posedge clk) begin
        if (state_q == EXPAND) rk_q[cnt_q] <= k_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            mode_q      <= 1'b0;
            x_q         <= '0;
            y_q         <= '0;
            k_q         <= '0;
            l_q         <= '0;
            data_out_q  <= '0;
            busy_q      <= 1'b0;
            finished_q  <= 1'b0;
            key_ready_q <= 1'b0;
        end else begin
            finished_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (signal_start) begin
                        mode_q <= mode;
                        l_q    <= key[2*WORD-1:WORD];
                        k_q    <= key[WORD-1:0];
                        x_q    <= data_in[2*WORD-1:WORD];
                        y_q    <= data_in[WORD-1:0];
                        cnt_q  <= '0;
                        busy_q <= 1'b1;
                        if (new_key || !key_ready_q) begin
                            key_ready_q <= 1'b0;
                            state_q     <= EXPAND;
                        end else begin
                            state_q <= RUN;
                        end
                    end
                end
                EXPAND: begin
                    k_q   <= k_d;
                    l_q   <= l_d;
                    cnt_q <= cnt_q + 1'b1;
                    if (last) begin
                        key_ready_q <= 1'b1;
                        state_q     <= RUN;
                    end
                end
                RUN: begin
                    x_q   <= x_d;
                    y_q   <= y_d;
                    cnt_q <= cnt_q + 1'b1;
                    if (last) begin
                        data_out_q <= {x_d, y_d};
                        finished_q <= 1'b1;
                        state_q    <= DONE;
                    end
                end
                DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign data_out       = data_out_q;
    assign busy           = busy_q;
    assign finished       = finished_q;
    assign key_ready      = key_ready_q;
    assign state_response = state_q;

endmodule

// File: tb/tb_speck_cipher_controller.sv
// Bench for speck_cipher_controller: vector table plus corner-case sequences,
// checked against a plain whole-block SPECK128/128 reference.
module tb_speck_cipher_controller;
    localparam logic [127:0] KEY = 128'h0f0e0d0c0b0a0908_0706050403020100;
    localparam logic [127:0] PT  = 128'h6c61766975716520_7469206564616d20;
    localparam logic [127:0] CT  = 128'ha65d985179783265_7860fedf5c570d18;

    logic         clk = 1'b0;
    logic         rst;
    logic         signal_start, mode, new_key;
    logic [127:0] key, data_in, data_out;
    logic         busy, finished, key_ready;
    logic [3:0]   state_response;

    int total = 0;
    int bad   = 0;

    speck_cipher_controller dut (
        .clk(clk), .rst(rst), .signal_start(signal_start), .mode(mode),
        .new_key(new_key), .key(key), .data_in(data_in), .data_out(data_out),
        .busy(busy), .finished(finished), .key_ready(key_ready),
        .state_response(state_response)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] ror64(input logic [63:0] v, input int n);
        return (v >> n) | (v << (64 - n));
    endfunction

    function automatic logic [63:0] rol64(input logic [63:0] v, input int n);
        return (v << n) | (v >> (64 - n));
    endfunction

    function automatic logic [127:0] speck(input logic dec, input logic [127:0] k, input logic [127:0] d);
        logic [63:0] rk [32];
        logic [63:0] a, b, x, y;
        a = k[63:0]; b = k[127:64]; x = d[127:64]; y = d[63:0];
        for (int i = 0; i < 32; i++) begin
            rk[i] = a;
            b = (a + ror64(b, 8)) ^ 64'(i);
            a = rol64(a, 3) ^ b;
        end
        for (int r = 0; r < 32; r++) begin
            if (!dec) begin
                x = (ror64(x, 8) + y) ^ rk[r];
                y = rol64(y, 3) ^ x;
            end else begin
                y = ror64(x ^ y, 3);
                x = rol64((x ^ rk[31 - r]) - y, 8);
            end
        end
        return {x, y};
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // Entered and left at a negedge in IDLE, so consecutive calls are back-to-back.
    task automatic run_op(input string nm, input logic m, input logic nk, input logic [127:0] k,
                          input logic [127:0] d, input logic [127:0] exp, input int exp_edges,
                          input bit pulse);
        logic [127:0] prev;
        int           edges;
        bit           stable;
        prev = data_out; stable = 1'b1;
        mode = m; new_key = nk; key = k; data_in = d; signal_start = 1'b1;
        @(negedge clk);
        signal_start = 1'b0; mode = ~m; new_key = ~nk;
        key     = {$urandom(), $urandom(), $urandom(), $urandom()};
        data_in = {$urandom(), $urandom(), $urandom(), $urandom()};
        chk({nm, " first_state"}, 128'(state_response), (exp_edges == 64) ? 128'd1 : 128'd2);
        edges = 0;
        while (!finished && edges < 200) begin
            if (data_out !== prev) stable = 1'b0;
            signal_start = pulse && (edges == 5 || edges == 40);
            @(negedge clk);
            edges++;
        end
        signal_start = 1'b0;
        chk({nm, " latency"}, 128'(edges), 128'(exp_edges));
        chk({nm, " done_state"}, 128'(state_response), 128'd3);
        chk({nm, " data_out"}, data_out, exp);
        chk({nm, " out_stable"}, 128'(stable), 128'd1);
        chk({nm, " key_ready"}, 128'(key_ready), 128'd1);
        @(negedge clk);
        chk({nm, " finished_1cyc"}, 128'(finished), 128'd0);
        chk({nm, " idle_state"}, 128'(state_response), 128'd0);
        chk({nm, " idle_busy"}, 128'(busy), 128'd0);
    endtask

    typedef struct {
        logic         m;
        logic         nk;
        logic [127:0] k;
        logic [127:0] d;
        logic [127:0] exp;
        int           edges;
        bit           pulse;
    } vec_t;

    vec_t         tbl [12];
    logic [127:0] mdl_key;
    bit           mdl_ready;

    initial begin
        // Table: the published vector, its inverse, a reuse, then random traffic.
        mdl_ready = 1'b0; mdl_key = '0;
        for (int i = 0; i < 12; i++) begin
            tbl[i].pulse = (i == 4 || i == 5);
            if (i == 0) begin
                tbl[i].m = 1'b0; tbl[i].nk = 1'b1; tbl[i].k = KEY; tbl[i].d = PT; tbl[i].exp = CT;
            end else if (i == 1) begin
                tbl[i].m = 1'b1; tbl[i].nk = 1'b0; tbl[i].k = '0; tbl[i].d = CT; tbl[i].exp = PT;
            end else if (i == 2) begin
                tbl[i].m = 1'b0; tbl[i].nk = 1'b0; tbl[i].k = KEY; tbl[i].d = PT; tbl[i].exp = CT;
            end else begin
                tbl[i].m  = 1'($urandom_range(0, 1));
                tbl[i].nk = (i == 4) ? 1'b1 : (i == 5) ? 1'b0 : ($urandom_range(0, 2) == 0);
                tbl[i].k  = {$urandom(), $urandom(), $urandom(), $urandom()};
                tbl[i].d  = {$urandom(), $urandom(), $urandom(), $urandom()};
            end
            tbl[i].edges = (tbl[i].nk || !mdl_ready) ? 64 : 32;
            if (tbl[i].nk || !mdl_ready) begin
                mdl_key   = tbl[i].k;
                mdl_ready = 1'b1;
            end
            if (i >= 3) tbl[i].exp = speck(tbl[i].m, mdl_key, tbl[i].d);
        end

        rst = 1'b1; signal_start = 1'b0; mode = 1'b0; new_key = 1'b0; key = '0; data_in = '0;
        repeat (2) @(negedge clk);
        chk("reset state", 128'(state_response), 128'd0);
        chk("reset busy", 128'(busy), 128'd0);
        chk("reset finished", 128'(finished), 128'd0);
        chk("reset key_ready", 128'(key_ready), 128'd0);
        chk("reset data_out", data_out, 128'd0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 12; i++)
            run_op($sformatf("vec%0d", i), tbl[i].m, tbl[i].nk, tbl[i].k, tbl[i].d,
                   tbl[i].exp, tbl[i].edges, tbl[i].pulse);

        // Reset lands at expansion step 10; the next start must re-expand.
        mode = 1'b0; new_key = 1'b1; key = KEY; data_in = PT; signal_start = 1'b1;
        @(negedge clk);
        signal_start = 1'b0;
        repeat (10) @(negedge clk);
        chk("pre-abort state", 128'(state_response), 128'd1);
        rst = 1'b1;
        #1;
        chk("abort state", 128'(state_response), 128'd0);
        chk("abort busy", 128'(busy), 128'd0);
        chk("abort key_ready", 128'(key_ready), 128'd0);
        chk("abort data_out", data_out, 128'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        run_op("post_abort", 1'b0, 1'b0, KEY, PT, CT, 64, 1'b0);
        run_op("post_abort_dec", 1'b1, 1'b0, '0, CT, PT, 32, 1'b1);

        repeat (3) @(negedge clk);
        chk("quiet idle", 128'(state_response), 128'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
